// File: rtl/game_sequencer.sv
// game_sequencer: key/button synchronizers, game FSM and per-frame paddle stepping.
// Drives the paddle row to the pixel generator and an ASCII status code to the display.
module game_sequencer #(
    parameter int unsigned FRAME_DIV = 1,
    parameter int unsigned STEP      = 4,
    parameter int unsigned Y_MIN     = 0,
    parameter int unsigned Y_MAX     = 408,
    parameter int unsigned Y_INIT    = 204
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_s,
    input  logic       key_p,
    input  logic       key_r,
    input  logic       key_esc,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       v_sync,
    output logic [1:0] state,
    output logic [9:0] paddle_y,
    output logic       move_up,
    output logic       move_down,
    output logic [7:0] status_code
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam int NIN = 9;
    localparam logic [7:0]         DIV_LAST = 8'(FRAME_DIV - 1);
    localparam logic [9:0]         Y_INIT_V = 10'(Y_INIT);
    localparam logic [9:0]         Y_MIN_V  = 10'(Y_MIN);
    localparam logic [9:0]         Y_MAX_V  = 10'(Y_MAX);
    localparam logic signed [10:0] STEP_S   = 11'(STEP);
    localparam logic signed [10:0] Y_MIN_S  = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S  = 11'(Y_MAX);

    // bit order: s, p, r, esc, key_up, key_down, btn_up, btn_down, v_sync
    logic [NIN-1:0] raw;
    logic [NIN-1:0] s1;
    logic [NIN-1:0] s2;
    logic [NIN-1:0] s3;
    logic [NIN-1:0] rise;

    state_t     st;
    logic [7:0] div;

    logic ev_s;
    logic ev_p;
    logic ev_r;
    logic ev_esc;
    logic frame;
    logic want_up;
    logic want_dn;

    logic signed [10:0] y_ext;
    logic signed [10:0] y_dec;
    logic signed [10:0] y_inc;
    logic [9:0]         y_up;
    logic [9:0]         y_dn;

    assign raw = {v_sync, btn_down, btn_up, key_down, key_up,
                  key_esc, key_r, key_p, key_s};

    // Two synchronizer flops plus an edge register; all idle high so held keys give no event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '1;
            s2 <= '1;
            s3 <= '1;
        end else begin
            s1 <= raw;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise    = s2 & ~s3;
    assign ev_s    = rise[0];
    assign ev_p    = rise[1];
    assign ev_r    = rise[2];
    assign ev_esc  = rise[3];
    assign frame   = ~s2[8] & s3[8];
    assign want_up = s2[4] | s2[6];
    assign want_dn = s2[5] | s2[7];

    // Saturating candidate positions; signed 11-bit math keeps the low side from wrapping.
    always_comb begin
        y_ext = signed'({1'b0, paddle_y});
        y_dec = y_ext - STEP_S;
        y_inc = y_ext + STEP_S;
        y_up  = (y_dec < Y_MIN_S) ? Y_MIN_V : y_dec[9:0];
        y_dn  = (y_inc > Y_MAX_S) ? Y_MAX_V : y_inc[9:0];
    end

    // Game FSM with prioritized commands, frame divider and paddle stepping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= IDLE;
            div         <= '0;
            paddle_y    <= Y_INIT_V;
            move_up     <= 1'b0;
            move_down   <= 1'b0;
            status_code <= 8'h49;
        end else begin
            move_up   <= 1'b0;
            move_down <= 1'b0;

            case (st)
                IDLE:    status_code <= 8'h49;
                RUN:     status_code <= 8'h47;
                PAUSE:   status_code <= 8'h50;
                HALT:    status_code <= 8'h48;
                default: status_code <= 8'h49;
            endcase

            priority case (1'b1)
                ev_esc: st <= HALT;
                ev_r: begin
                    st       <= IDLE;
                    paddle_y <= Y_INIT_V;
                    div      <= '0;
                end
                ev_p: begin
                    if (st == RUN) begin
                        st <= PAUSE;
                    end else if (st == PAUSE) begin
                        st <= RUN;
                    end
                end
                ev_s: begin
                    if (st == IDLE) begin
                        st  <= RUN;
                        div <= '0;
                    end else if (st == PAUSE) begin
                        st <= RUN;
                    end
                end
                (frame && st == RUN): begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (want_up && !want_dn && y_up != paddle_y) begin
                            paddle_y <= y_up;
                            move_up  <= 1'b1;
                        end else if (want_dn && !want_up && y_dn != paddle_y) begin
                            paddle_y  <= y_dn;
                            move_down <= 1'b1;
                        end
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = st;

endmodule
